serial_tx_frame: RTL and testbench

- Parallel-in, serial-out frame transmitter built on the team's flip-flop primitives.
- Accepts a DATA_W-bit word through a valid/ready handshake.
- Emits an asynchronous-style serial frame on a single line: start bit, data bits LSB first, optional parity, stop bit.
- Each bit is held for CLKS_PER_BIT clocks. This is the sending end of the serial link whose receiver samples the line with flip-flops.

---
 rtl/serial_tx_frame_if.sv | 11 +
 rtl/serial_tx_frame.sv | 100 ++++++++++
 tb/tb_serial_tx_frame.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_frame_if.sv
// serial_tx_frame_if: valid/ready word input and serial frame status outputs
interface serial_tx_frame_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;
  logic              tx;
  logic              busy;
  logic              done;
  modport master (output data_in, valid, input ready, tx, busy, done);
  modport slave  (input data_in, valid, output ready, tx, busy, done);
endinterface

// File: rtl/serial_tx_frame.sv
// serial_tx_frame: start bit, LSB-first data, optional parity, stop bit, each held CLKS_PER_BIT clocks
module serial_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_tx_frame_if.slave bus
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("serial_tx_frame: PARITY must be 0, 1 or 2");
  end
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last;
  assign last = cnt_q == CNT_LAST;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = last ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.valid) begin
          state_d = START;
          shreg_d = bus.data_in;
          par_d   = ^bus.data_in ^ (PARITY == 2);
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: if (last) begin
        state_d = DATA;
        idx_d   = '0;
        tx_d    = shreg_q[0];
      end
      DATA: if (last) begin
        if (idx_q == IDX_LAST) begin
          state_d = PARITY != 0 ? PAR : STOP;
          tx_d    = PARITY != 0 ? par_q : 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          shreg_d = shreg_q >> 1;
          tx_d    = shreg_d[0];
        end
      end
      PAR: if (last) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (last) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign bus.ready = state_q == IDLE;
  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_tx_frame.sv
// tb_serial_tx_frame: three parity variants checked against a frame-level reference model
module tb_serial_tx_frame;
  localparam int DW = 8, CPB = 4;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  int checks = 0, errors = 0;
  logic tx_w [3], busy_w [3], done_w [3], ready_w [3];
  bit mq [3][$];
  bit eact [3], etx [3], ebusy [3], edone [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_tx_frame_if #(.DATA_W(DW)) b ();
    serial_tx_frame #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY(g)) u (.clk(clk), .rst_n(rst_n), .bus(b));
    assign b.data_in  = data_in;
    assign b.valid    = valid;
    assign tx_w[g]    = b.tx;
    assign busy_w[g]  = b.busy;
    assign done_w[g]  = b.done;
    assign ready_w[g] = b.ready;
  end
  // Expected line per cycle: a whole frame is queued as a bit list at acceptance and replayed.
  function automatic void model_step();
    for (int k = 0; k < 3; k++) begin
      edone[k] = 1'b0;
      if (!rst_n) begin
        mq[k].delete();
        eact[k] = 1'b0; etx[k] = 1'b1; ebusy[k] = 1'b0;
      end else if (eact[k] && mq[k].size() == 0) begin
        eact[k] = 1'b0; etx[k] = 1'b1; ebusy[k] = 1'b0; edone[k] = 1'b1;
      end else if (eact[k]) begin
        etx[k] = mq[k].pop_front();
      end else if (valid) begin
        for (int b = 0; b < DW + 2 + (k != 0); b++) begin
          bit v;
          if (b == 0) v = 1'b0;
          else if (b <= DW) v = data_in[b-1];
          else if (k != 0 && b == DW + 1) v = (^data_in) ^ (k == 2);
          else v = 1'b1;
          for (int r = 0; r < CPB; r++) mq[k].push_back(v);
        end
        etx[k] = mq[k].pop_front(); eact[k] = 1'b1; ebusy[k] = 1'b1;
      end
    end
  endfunction
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1; data_in = DW'($urandom);
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 || ready_w[k] !== 1'b1) begin
          errors++;
          $display("FAIL reset_hold[%0d] c%0d: tx=%b busy=%b done=%b ready=%b, want 1 0 0 1", k, c, tx_w[k], busy_w[k], done_w[k], ready_w[k]);
        end
      end
    end
    rst_n = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (tx_w[k] !== 1'b0 || busy_w[k] !== 1'b1 || ready_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_first_accept[%0d]: tx=%b busy=%b ready=%b, want 0 1 0", k, tx_w[k], busy_w[k], ready_w[k]);
      end
    end
    for (int c = 0; c < 50; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_w[k], busy_w[k], done_w[k], ready_w[k]} !== {etx[k], ebusy[k], edone[k], ~eact[k]}) begin
          errors++;
          $display("FAIL reset_drain[%0d] c%0d: tx/busy/done/ready=%b%b%b%b, want %b%b%b%b", k, c, tx_w[k], busy_w[k], done_w[k], ready_w[k], etx[k], ebusy[k], edone[k], ~eact[k]);
        end
      end
    end
  endtask
  task automatic test_single_parity();
    logic [10:0] ev [3];
    int nbusy [3], ndone [3];
    ev[0] = 11'b111_0100_1010;
    ev[1] = 11'b101_0100_1010;
    ev[2] = 11'b111_0100_1010;
    nbusy = '{0, 0, 0}; ndone = '{0, 0, 0};
    valid = 1'b1; data_in = 8'hA5;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 48; c++) begin
      for (int k = 0; k < 3; k++) begin
        int len;
        len = (k == 0) ? 40 : 44;
        nbusy[k] += int'(busy_w[k]);
        ndone[k] += int'(done_w[k]);
        checks++;
        if (c < len && (tx_w[k] !== ev[k][c/CPB] || busy_w[k] !== 1'b1 || done_w[k] !== 1'b0 || ready_w[k] !== 1'b0)) begin
          errors++;
          $display("FAIL frame_a5[%0d] c%0d: tx=%b busy=%b done=%b ready=%b, want %b 1 0 0", k, c, tx_w[k], busy_w[k], done_w[k], ready_w[k], ev[k][c/CPB]);
        end else if (c == len && (done_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || tx_w[k] !== 1'b1)) begin
          errors++;
          $display("FAIL done_a5[%0d] c%0d: done=%b busy=%b tx=%b, want 1 0 1", k, c, done_w[k], busy_w[k], tx_w[k]);
        end
        data_in = DW'($urandom);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (nbusy[k] != ((k == 0) ? 40 : 44) || ndone[k] != 1) begin
        errors++;
        $display("FAIL len_a5[%0d]: busy cycles=%0d done pulses=%0d, want %0d 1", k, nbusy[k], ndone[k], (k == 0) ? 40 : 44);
      end
    end
  endtask
  task automatic test_back_to_back();
    int ndone [3];
    int first_done;
    ndone = '{0, 0, 0}; first_done = -1;
    valid = 1'b1; data_in = 8'h01;
    tick();
    data_in = 8'hFF;
    for (int c = 0; c < 150; c++) begin
      if (c == 50) valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        ndone[k] += int'(done_w[k]);
        checks++;
        if ({tx_w[k], busy_w[k], done_w[k], ready_w[k]} !== {etx[k], ebusy[k], edone[k], ~eact[k]}) begin
          errors++;
          $display("FAIL b2b[%0d] c%0d: tx/busy/done/ready=%b%b%b%b, want %b%b%b%b", k, c, tx_w[k], busy_w[k], done_w[k], ready_w[k], etx[k], ebusy[k], edone[k], ~eact[k]);
        end
      end
      if (first_done < 0 && done_w[0] === 1'b1) first_done = c;
      if (first_done >= 0 && c == first_done + 1) begin
        checks++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_start: tx=%b busy=%b after done, want 0 1", tx_w[0], busy_w[0]);
        end
      end
      tick();
    end
    checks++;
    if (first_done != 40) begin
      errors++;
      $display("FAIL b2b_done_time: first done at c%0d, want c40", first_done);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ndone[k] != 2) begin
        errors++;
        $display("FAIL b2b_count[%0d]: done pulses=%0d, want 2", k, ndone[k]);
      end
    end
  endtask
  task automatic test_ignore_busy();
    logic [DW-1:0] rx;
    int ndone;
    rx = '0; ndone = 0;
    valid = 1'b1; data_in = 8'h3C;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c >= 6 && (c - 6) % CPB == 0 && (c - 6) / CPB < DW) rx[(c-6)/CPB] = tx_w[0];
      ndone += int'(done_w[0]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_w[k], busy_w[k], done_w[k], ready_w[k]} !== {etx[k], ebusy[k], edone[k], ~eact[k]}) begin
          errors++;
          $display("FAIL ignore[%0d] c%0d: tx/busy/done/ready=%b%b%b%b, want %b%b%b%b", k, c, tx_w[k], busy_w[k], done_w[k], ready_w[k], etx[k], ebusy[k], edone[k], ~eact[k]);
        end
      end
      valid = (c == 10);
      data_in = (c == 10) ? 8'hC3 : DW'($urandom);
      tick();
    end
    checks++;
    if (rx !== 8'h3C || ndone != 1 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL ignore_word: rx=%h done pulses=%0d busy=%b, want 3c 1 0", rx, ndone, busy_w[0]);
    end
  endtask
  task automatic test_mid_reset();
    logic [DW-1:0] rx;
    int ndone;
    rx = '0; ndone = 0;
    valid = 1'b1; data_in = DW'($urandom);
    tick();
    valid = 1'b0;
    repeat (17) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset[%0d]: tx=%b busy=%b done=%b, want 1 0 0", k, tx_w[k], busy_w[k], done_w[k]);
      end
    end
    for (int c = 0; c < 50; c++) begin
      tick();
      for (int k = 0; k < 3; k++) ndone += int'(done_w[k]);
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL mid_reset_done: %0d done pulses after abort, want 0", ndone);
    end
    valid = 1'b1; data_in = 8'h55;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 48; c++) begin
      if (c >= 6 && (c - 6) % CPB == 0 && (c - 6) / CPB < DW) rx[(c-6)/CPB] = tx_w[0];
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_w[k], busy_w[k], done_w[k], ready_w[k]} !== {etx[k], ebusy[k], edone[k], ~eact[k]}) begin
          errors++;
          $display("FAIL after_reset[%0d] c%0d: tx/busy/done/ready=%b%b%b%b, want %b%b%b%b", k, c, tx_w[k], busy_w[k], done_w[k], ready_w[k], etx[k], ebusy[k], edone[k], ~eact[k]);
        end
      end
      tick();
    end
    checks++;
    if (rx !== 8'h55) begin
      errors++;
      $display("FAIL after_reset_word: rx=%h, want 55", rx);
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      valid = $urandom_range(0, 3) == 0;
      data_in = DW'($urandom);
      rst_n = c >= 1450 || $urandom_range(0, 199) != 0;
      if (c >= 1450) valid = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_w[k], busy_w[k], done_w[k], ready_w[k]} !== {etx[k], ebusy[k], edone[k], ~eact[k]}) begin
          errors++;
          $display("FAIL random[%0d] c%0d: tx/busy/done/ready=%b%b%b%b, want %b%b%b%b", k, c, tx_w[k], busy_w[k], done_w[k], ready_w[k], etx[k], ebusy[k], edone[k], ~eact[k]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_single_parity();
    test_back_to_back();
    test_ignore_busy();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
